comp_mult_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one complex multiplier instance (val-rdy operand and result interfaces, {x1,y1,x2,y2} in, {xr,yr} out) between NREQ requesters.
- Accepts one operand set at a time, issues it to the multiplier, captures the result and returns it to the originating requester.
- Sits between requester clients and the multiplier. The multiplier shares clk/rst_n/sw_rst with this block.

---
 rtl/comp_mult_arb_pkg.sv | 27 ++
 rtl/comp_mult_rr_pick.sv | 39 +++
 rtl/comp_mult_arb.sv | 185 ++++++++++++++++++
 tb/tb_comp_mult_arb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_mult_arb_pkg.sv
// Shared types and width helpers for the complex-multiplier arbiter.
package comp_mult_arb_pkg;

    // Sequencer states: one operand set is in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    // Operand bundle {x1,y1,x2,y2}.
    function automatic int op_w(input int dwidth);
        return 4 * dwidth;
    endfunction

    // Result bundle {xr,yr}, each 2*(DWIDTH+1) bits wide.
    function automatic int res_w(input int dwidth);
        return 4 * (dwidth + 1);
    endfunction

    // Requester id width; never below one bit.
    function automatic int id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/comp_mult_rr_pick.sv
// Round-robin pick: first asserted request at or above ptr, wrapping around.
module comp_mult_rr_pick
    import comp_mult_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int ID_W = id_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] gnt_oh,
    output logic [ID_W-1:0] gnt_idx,
    output logic            any
);

    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;

    // Walk NREQ positions starting at ptr; the first live request wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NREQ)) begin
                sum = sum - (ID_W+1)'(NREQ);
            end
            idx = sum[ID_W-1:0];
            if (!any && req[idx]) begin
                any         = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/comp_mult_arb.sv
// Shares one val-rdy complex multiplier between NREQ requesters.
// Handshake rule on every interface: a transfer happens on a rising clock
// edge where valid and ready are both high; valid never waits on ready, and
// data is held stable while valid is high and ready is low.
module comp_mult_arb
    import comp_mult_arb_pkg::*;
#(
    parameter  int DWIDTH = 8,
    parameter  int NREQ   = 4,
    parameter  int CNT_W  = 16,
    localparam int OP_W   = op_w(DWIDTH),
    localparam int RES_W  = res_w(DWIDTH),
    localparam int ID_W   = id_w(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rst,
    input  logic [NREQ-1:0]      op_val,
    output logic [NREQ-1:0]      op_rdy,
    input  logic [NREQ*OP_W-1:0] op_data,
    output logic [NREQ-1:0]      res_val,
    input  logic [NREQ-1:0]      res_rdy,
    output logic [RES_W-1:0]     res_data,
    output logic                 mul_op_val,
    input  logic                 mul_op_rdy,
    output logic [OP_W-1:0]      mul_op_data,
    input  logic                 mul_res_val,
    output logic                 mul_res_rdy,
    input  logic [RES_W-1:0]     mul_res_data,
    output logic [ID_W-1:0]      gnt_id,
    output logic [CNT_W-1:0]     txn_cnt,
    output logic                 err_spur,
    output logic [1:0]           dbg_state
);

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [OP_W-1:0] op_buf;
    logic [RES_W-1:0] res_buf;

    logic [NREQ-1:0] pick_oh;
    logic [ID_W-1:0] pick_idx;
    logic            pick_any;
    logic [OP_W-1:0] pick_data;
    logic [NREQ-1:0] gnt_oh;

    logic            op_fire;
    logic            res_cap;
    logic            ret_fire;
    logic            spur_hit;
    logic [ID_W-1:0] rr_nxt;

    comp_mult_rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req     (op_val),
        .ptr     (rr_ptr),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // Route the picked requester's operand slice to the operand buffer.
    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                pick_data = op_data[i*OP_W +: OP_W];
            end
        end
    end

    // Decode the served requester id for result steering.
    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_oh[i] = (gnt_id == ID_W'(i));
        end
    end

    // Next-state and handshake outputs of the sequencer.
    always_comb begin
        state_nxt   = state;
        op_rdy      = '0;
        res_val     = '0;
        mul_op_val  = 1'b0;
        mul_res_rdy = 1'b1;
        op_fire     = 1'b0;
        res_cap     = 1'b0;
        ret_fire    = 1'b0;
        case (state)
            ST_IDLE: begin
                // pick_oh only marks a requester whose op_val is high,
                // so offering ready to it is already a handshake.
                op_rdy = pick_oh;
                if (pick_any) begin
                    op_fire   = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mul_op_val = 1'b1;
                if (mul_op_rdy) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mul_res_val) begin
                    res_cap   = 1'b1;
                    state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                // Hold the multiplier's result side closed until the
                // buffered result has gone back to its owner.
                mul_res_rdy = 1'b0;
                res_val     = gnt_oh;
                if (|(res_rdy & gnt_oh)) begin
                    ret_fire  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // A result arriving before an operand set was issued has no owner.
    assign spur_hit = mul_res_val && ((state == ST_IDLE) || (state == ST_ISSUE));

    // Pointer moves to just past the requester that completed.
    assign rr_nxt = (gnt_id == ID_W'(NREQ-1)) ? '0 : gnt_id + ID_W'(1);

    // State register; sw_rst has the same effect as rst_n, synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else if (sw_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Buffers, grant id, round-robin pointer, counter and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            op_buf   <= '0;
            res_buf  <= '0;
            gnt_id   <= '0;
            txn_cnt  <= '0;
            err_spur <= 1'b0;
        end else if (sw_rst) begin
            rr_ptr   <= '0;
            op_buf   <= '0;
            res_buf  <= '0;
            gnt_id   <= '0;
            txn_cnt  <= '0;
            err_spur <= 1'b0;
        end else begin
            if (op_fire) begin
                op_buf <= pick_data;
                gnt_id <= pick_idx;
            end
            if (res_cap) begin
                res_buf <= mul_res_data;
            end
            if (ret_fire) begin
                rr_ptr  <= rr_nxt;
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
            if (spur_hit) begin
                err_spur <= 1'b1;
            end
        end
    end

    assign mul_op_data = op_buf;
    assign res_data    = res_buf;
    assign dbg_state   = state;

endmodule

// File: tb/tb_comp_mult_arb.sv
// Bench for comp_mult_arb with a behavioural one-register complex multiplier.
module tb_comp_mult_arb;

    localparam int DWIDTH = 8;
    localparam int NREQ   = 4;
    localparam int CNT_W  = 16;
    localparam int OP_W   = 4 * DWIDTH;
    localparam int RES_W  = 4 * (DWIDTH + 1);
    localparam int ID_W   = 2;

    logic                 clk;
    logic                 rst_n;
    logic                 sw_rst;
    logic [NREQ-1:0]      op_val;
    logic [NREQ-1:0]      op_rdy;
    logic [NREQ*OP_W-1:0] op_data;
    logic [NREQ-1:0]      res_val;
    logic [NREQ-1:0]      res_rdy;
    logic [RES_W-1:0]     res_data;
    logic                 mul_op_val;
    logic                 mul_op_rdy;
    logic [OP_W-1:0]      mul_op_data;
    logic                 mul_res_val;
    logic                 mul_res_rdy;
    logic [RES_W-1:0]     mul_res_data;
    logic [ID_W-1:0]      gnt_id;
    logic [CNT_W-1:0]     txn_cnt;
    logic                 err_spur;
    logic [1:0]           dbg_state;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    comp_mult_arb #(
        .DWIDTH (DWIDTH),
        .NREQ   (NREQ),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sw_rst       (sw_rst),
        .op_val       (op_val),
        .op_rdy       (op_rdy),
        .op_data      (op_data),
        .res_val      (res_val),
        .res_rdy      (res_rdy),
        .res_data     (res_data),
        .mul_op_val   (mul_op_val),
        .mul_op_rdy   (mul_op_rdy),
        .mul_op_data  (mul_op_data),
        .mul_res_val  (mul_res_val),
        .mul_res_rdy  (mul_res_rdy),
        .mul_res_data (mul_res_data),
        .gnt_id       (gnt_id),
        .txn_cnt      (txn_cnt),
        .err_spur     (err_spur),
        .dbg_state    (dbg_state)
    );

    // Full-precision signed complex product, {xr,yr} each 18 bits.
    function automatic logic [RES_W-1:0] cmul(input logic [OP_W-1:0] d);
        int x1, y1, x2, y2, xr, yr;
        x1 = int'($signed(d[31:24]));
        y1 = int'($signed(d[23:16]));
        x2 = int'($signed(d[15:8]));
        y2 = int'($signed(d[7:0]));
        xr = x1 * x2 - y1 * y2;
        yr = x1 * y2 + y1 * x2;
        return {xr[17:0], yr[17:0]};
    endfunction

    // ---------------- multiplier model ----------------
    logic             mul_full;
    logic             spur_inj;
    logic [RES_W-1:0] mul_q;

    assign mul_op_rdy   = ~mul_full;
    assign mul_res_val  = mul_full | spur_inj;
    assign mul_res_data = mul_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_full <= 1'b0;
            mul_q    <= '0;
        end else if (sw_rst) begin
            mul_full <= 1'b0;
            mul_q    <= '0;
        end else if (mul_op_val && mul_op_rdy) begin
            mul_full <= 1'b1;
            mul_q    <= cmul(mul_op_data);
        end else if (mul_res_val && mul_res_rdy) begin
            mul_full <= 1'b0;
        end
    end

    // ---------------- scoreboard / reference state ----------------
    logic [OP_W-1:0]  pend_q[NREQ][$];
    logic [RES_W-1:0] exp_q[$];
    int               grant_log[$];
    int               cyc, hs_cyc, m_rr, m_gnt, m_done, rdy_pct;
    bit               m_busy, m_err;
    logic [NREQ-1:0]  bp_mask;
    logic [OP_W-1:0]  m_op;
    logic [RES_W-1:0] last_res;
    int               n_checks, n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int ref_pick();
        for (int k = 0; k < NREQ; k++) begin
            if (pend_q[(m_rr + k) % NREQ].size() != 0) return (m_rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < NREQ; i++) begin
            if (pend_q[i].size() != 0) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_rr   = 0;
        m_done = 0;
        m_err  = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            op_val[i] = (pend_q[i].size() != 0);
            op_data[i*OP_W +: OP_W] = (pend_q[i].size() != 0) ? pend_q[i][0] : OP_W'($urandom());
            res_rdy[i] = (int'($urandom_range(0, 99)) < rdy_pct) && !bp_mask[i];
        end
    endtask

    // One clock: check outputs at negedge, then advance the model after posedge.
    task automatic step();
        int pick;
        bit hs_op, hs_res, in_ret, exp_mov;
        logic [NREQ-1:0] exp_rdy, exp_rv;
        hs_op  = 1'b0;
        hs_res = 1'b0;
        pick   = -1;
        @(negedge clk);
        in_ret = m_busy && (cyc - hs_cyc >= 3);
        if (!m_busy) begin
            pick    = ref_pick();
            exp_rdy = (pick >= 0) ? (NREQ'(1) << pick) : '0;
            hs_op   = (pick >= 0);
        end else begin
            exp_rdy = '0;
        end
        check("op_rdy", 64'(op_rdy), 64'(exp_rdy));
        exp_rv = in_ret ? (NREQ'(1) << m_gnt) : '0;
        check("res_val", 64'(res_val), 64'(exp_rv));
        if (in_ret) begin
            if (exp_q.size() != 0) check("res_data", 64'(res_data), 64'(exp_q[0]));
            last_res = res_data;
            hs_res   = res_rdy[m_gnt];
        end
        exp_mov = m_busy && (cyc - hs_cyc == 1);
        check("mul_op_val", 64'(mul_op_val), 64'(exp_mov));
        if (exp_mov) check("mul_op_data", 64'(mul_op_data), 64'(m_op));
        check("mul_res_rdy", 64'(mul_res_rdy), 64'(!in_ret));
        if (m_busy) check("gnt_id", 64'(gnt_id), 64'(m_gnt));
        check("txn_cnt", 64'(txn_cnt), 64'(CNT_W'(m_done)));
        check("err_spur", 64'(err_spur), 64'(m_err));
        if (hs_op) hs_cyc = cyc;
        @(posedge clk);
        #1;
        if (sw_rst) begin
            model_reset();
        end else begin
            if (hs_op) begin
                m_busy = 1'b1;
                m_gnt  = pick;
                m_op   = pend_q[pick][0];
                exp_q.push_back(cmul(pend_q[pick][0]));
                grant_log.push_back(pick);
                void'(pend_q[pick].pop_front());
            end
            if (hs_res) begin
                m_busy = 1'b0;
                m_rr   = (m_gnt + 1) % NREQ;
                m_done++;
                void'(exp_q.pop_front());
            end
            if (spur_inj) m_err = 1'b1;
        end
        cyc++;
        drive();
    endtask

    task automatic run_idle(input int maxc);
        int n;
        n = 0;
        while ((pending() || m_busy) && n < maxc) begin
            step();
            n++;
        end
        check("drain_timeout", 64'(pending() || m_busy), 64'(0));
    endtask

    task automatic sw_pulse();
        sw_rst = 1'b1;
        step();
        sw_rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n, base, pushed, r;
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        hs_cyc   = 0;
        m_gnt    = 0;
        m_op     = '0;
        last_res = '0;
        rst_n    = 1'b0;
        sw_rst   = 1'b0;
        spur_inj = 1'b0;
        bp_mask  = '0;
        rdy_pct  = 100;
        op_val   = '0;
        op_data  = '0;
        res_rdy  = '0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_op_rdy", 64'(op_rdy), 64'(0));
        check("rst_res_val", 64'(res_val), 64'(0));
        check("rst_mul_op_val", 64'(mul_op_val), 64'(0));
        check("rst_mul_res_rdy", 64'(mul_res_rdy), 64'(1));
        check("rst_gnt_id", 64'(gnt_id), 64'(0));
        check("rst_txn_cnt", 64'(txn_cnt), 64'(0));
        check("rst_err_spur", 64'(err_spur), 64'(0));
        check("rst_state", 64'(dbg_state), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive();

        // Fairness: everyone requesting, results always accepted
        for (int i = 0; i < NREQ; i++) begin
            pend_q[i].push_back($urandom());
            pend_q[i].push_back($urandom());
        end
        drive();
        run_idle(200);
        check("fair_count", 64'(grant_log.size()), 64'(8));
        for (int k = 0; k < 5; k++) check("fair_order", 64'(grant_log[k]), 64'(exp_order[k]));

        // Single request from requester 1
        sw_pulse();
        grant_log.delete();
        pend_q[1].push_back(32'h030402FF);
        drive();
        run_idle(50);
        check("single_gnt", 64'(grant_log[0]), 64'(1));
        check("single_res", 64'(last_res), 64'({18'd10, 18'd5}));
        check("single_cnt", 64'(txn_cnt), 64'(1));

        // Signed extreme operands
        pend_q[0].push_back(32'h80808080);
        drive();
        run_idle(50);
        check("signed_res", 64'(last_res), 64'({18'd0, 18'h08000}));

        // Result backpressure on requester 2 while others wait
        bp_mask = 4'b0100;
        pend_q[2].push_back($urandom());
        drive();
        n = 0;
        while (!m_busy && n < 20) begin step(); n++; end
        for (int i = 0; i < NREQ; i++) if (i != 2) pend_q[i].push_back($urandom());
        drive();
        while (!(m_busy && (cyc - hs_cyc >= 3)) && n < 40) begin step(); n++; end
        check("bp_gnt", 64'(m_gnt), 64'(2));
        repeat (10) step();
        bp_mask = '0;
        drive();
        run_idle(200);

        // sw_rst while waiting for the multiplier result
        pend_q[3].push_back($urandom());
        drive();
        n = 0;
        while (!m_busy && n < 20) begin step(); n++; end
        step();
        sw_pulse();
        check("swrst_state", 64'(dbg_state), 64'(0));
        check("swrst_cnt", 64'(txn_cnt), 64'(0));
        repeat (4) step();
        pend_q[3].push_back($urandom());
        drive();
        run_idle(50);
        check("swrst_after_cnt", 64'(txn_cnt), 64'(1));

        // Spurious result while idle: sticky until sw_rst
        spur_inj = 1'b1;
        step();
        spur_inj = 1'b0;
        repeat (3) step();
        pend_q[0].push_back($urandom());
        drive();
        run_idle(50);
        check("spur_sticky", 64'(err_spur), 64'(1));
        sw_pulse();
        check("spur_sw_clear", 64'(err_spur), 64'(0));

        // Spurious again, cleared by the asynchronous reset
        spur_inj = 1'b1;
        step();
        spur_inj = 1'b0;
        step();
        rst_n = 1'b0;
        #2;
        check("spur_rst_clear", 64'(err_spur), 64'(0));
        check("rst_async_cnt", 64'(txn_cnt), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        drive();

        // Random traffic with random result readiness
        rdy_pct = 70;
        base    = m_done;
        pushed  = 0;
        for (int t = 0; t < 600; t++) begin
            if ($urandom_range(0, 99) < 30) begin
                r = int'($urandom_range(0, NREQ-1));
                if (pend_q[r].size() < 3) begin
                    pend_q[r].push_back($urandom());
                    pushed++;
                    drive();
                end
            end
            step();
        end
        run_idle(800);
        check("rand_done", 64'(txn_cnt), 64'(CNT_W'(base + pushed)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit
    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

endmodule
